// File: rtl/dmem_store_buffer.sv
// Posted-write store buffer between the processor DMEM port and dmem; stores drain in FIFO order when loads leave the port free.
// Optional store-to-load forwarding of full-word stores is enabled by defining STBUF_FWD_EN.
module dmem_store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          st_valid,
  output logic          st_ready,
  input  logic [AW-1:0] st_addr,
  input  logic [31:0]   st_data,
  input  logic          st_byte,
  input  logic          st_half_word,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [AW-1:0] ld_addr,
  input  logic          ld_byte,
  input  logic          ld_half_word,
  input  logic          ld_sign_extend,
  output logic [31:0]   ld_data,
  output logic          empty,
  output logic [AW-1:0] addr_to_mem,
  output logic [31:0]   data_to_mem,
  output logic          write_enable_to_mem,
  output logic          byte_to_mem,
  output logic          half_word_to_mem,
  output logic          sign_extend_to_mem,
  input  logic [31:0]   data_from_mem
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0]    ent_addr_q [DEPTH];
  logic [AW-1:0]    ent_addr_d [DEPTH];
  logic [31:0]      ent_data_q [DEPTH];
  logic [31:0]      ent_data_d [DEPTH];
  logic [DEPTH-1:0] ent_byte_q, ent_byte_d;
  logic [DEPTH-1:0] ent_half_q, ent_half_d;

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic [DEPTH-1:0] ent_vld;
  logic [DEPTH-1:0] match;
  logic             hazard;
  logic             push;
  logic             drain;

`ifdef STBUF_FWD_EN
  logic [PW-1:0] idx;
  logic [PW-1:0] fwd_idx;
  logic          fwd_found;
  logic          fwd_ok;
`endif

  assign st_ready = (count_q != CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign push     = st_valid && st_ready;

  // An entry is live when its distance from head is below the occupancy.
  always_comb begin
    ent_vld = '0;
    match   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ent_vld[i] = (CW'(PW'(PW'(i) - head_q)) < count_q);
      match[i]   = ent_vld[i] && (ent_addr_q[i][AW-1:2] == ld_addr[AW-1:2]);
    end
    hazard = ld_valid && (match != '0);
  end

`ifdef STBUF_FWD_EN
  // Walk oldest to youngest so the last hit is the youngest matching store.
  always_comb begin
    idx       = head_q;
    fwd_idx   = head_q;
    fwd_found = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_q + PW'(k);
      if (match[idx]) begin
        fwd_found = 1'b1;
        fwd_idx   = idx;
      end
    end
    fwd_ok = fwd_found && !ent_byte_q[fwd_idx] && !ent_half_q[fwd_idx] &&
             (ent_addr_q[fwd_idx][1:0] == 2'b00) && !ld_byte && !ld_half_word;
  end
`endif

  // Port arbitration: a non-hazarding load owns the port, otherwise the head drains.
  always_comb begin
    addr_to_mem         = '0;
    data_to_mem         = '0;
    write_enable_to_mem = 1'b0;
    byte_to_mem         = 1'b0;
    half_word_to_mem    = 1'b0;
    sign_extend_to_mem  = 1'b0;
    ld_ready            = 1'b0;
    ld_data             = '0;
    drain               = 1'b0;
    if (ld_valid && !hazard) begin
      addr_to_mem        = ld_addr;
      byte_to_mem        = ld_byte;
      half_word_to_mem   = ld_half_word;
      sign_extend_to_mem = ld_sign_extend;
      ld_ready           = 1'b1;
      ld_data            = data_from_mem;
    end else if (count_q != '0) begin
      drain               = 1'b1;
      addr_to_mem         = ent_addr_q[head_q];
      data_to_mem         = ent_data_q[head_q];
      write_enable_to_mem = 1'b1;
      byte_to_mem         = ent_byte_q[head_q];
      half_word_to_mem    = ent_half_q[head_q];
`ifdef STBUF_FWD_EN
      if (hazard && fwd_ok) begin
        ld_ready = 1'b1;
        ld_data  = ent_data_q[fwd_idx];
      end
`endif
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_addr_d[i] = ent_addr_q[i];
      ent_data_d[i] = ent_data_q[i];
    end
    ent_byte_d = ent_byte_q;
    ent_half_d = ent_half_q;
    if (push) begin
      ent_addr_d[tail_q] = st_addr;
      ent_data_d[tail_q] = st_data;
      ent_byte_d[tail_q] = st_byte;
      ent_half_d[tail_q] = st_half_word && !st_byte;
    end
    head_d = drain ? head_q + PW'(1) : head_q;
    tail_d = push  ? tail_q + PW'(1) : tail_q;
    case ({push, drain})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry payload carries no reset; liveness comes from head/count alone.
  always_ff @(posedge clock) begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_addr_q[i] <= ent_addr_d[i];
      ent_data_q[i] <= ent_data_d[i];
    end
    ent_byte_q <= ent_byte_d;
    ent_half_q <= ent_half_d;
  end

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Bench for dmem_store_buffer: per-cycle vector table plus hand-written full-buffer and reset sequences, with a byte-addressed dmem model.
module tb_dmem_store_buffer;

  logic        clock;
  logic        reset;
  logic        st_valid, st_ready, st_byte, st_half_word;
  logic [31:0] st_addr, st_data;
  logic        ld_valid, ld_ready, ld_byte, ld_half_word, ld_sign_extend;
  logic [31:0] ld_addr, ld_data;
  logic        empty;
  logic [31:0] addr_to_mem, data_to_mem, data_from_mem;
  logic        write_enable_to_mem, byte_to_mem, half_word_to_mem, sign_extend_to_mem;

  dmem_store_buffer #(.DEPTH(4), .AW(32)) dut (
    .clock(clock), .reset(reset),
    .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr), .st_data(st_data),
    .st_byte(st_byte), .st_half_word(st_half_word),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_byte(ld_byte),
    .ld_half_word(ld_half_word), .ld_sign_extend(ld_sign_extend), .ld_data(ld_data),
    .empty(empty), .addr_to_mem(addr_to_mem), .data_to_mem(data_to_mem),
    .write_enable_to_mem(write_enable_to_mem), .byte_to_mem(byte_to_mem),
    .half_word_to_mem(half_word_to_mem), .sign_extend_to_mem(sign_extend_to_mem),
    .data_from_mem(data_from_mem)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Little-endian byte memory standing in for dmem, combinational read.
  logic [7:0]  mem [0:2047];
  logic [10:0] ra;
  logic [31:0] rw;
  logic [15:0] rh;
  logic [7:0]  rb;
  int          wr_cnt = 0;

  always_comb begin
    ra = addr_to_mem[10:0];
    rw = {mem[{ra[10:2], 2'd3}], mem[{ra[10:2], 2'd2}], mem[{ra[10:2], 2'd1}], mem[{ra[10:2], 2'd0}]};
    rh = {mem[{ra[10:1], 1'b1}], mem[{ra[10:1], 1'b0}]};
    rb = mem[ra];
    if (byte_to_mem)
      data_from_mem = sign_extend_to_mem ? {{24{rb[7]}}, rb} : {24'h0, rb};
    else if (half_word_to_mem)
      data_from_mem = sign_extend_to_mem ? {{16{rh[15]}}, rh} : {16'h0, rh};
    else
      data_from_mem = rw;
  end

  always @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < 2048; i++) mem[i] <= 8'h00;
    end else if (write_enable_to_mem) begin
      wr_cnt <= wr_cnt + 1;
      if (byte_to_mem) begin
        mem[addr_to_mem[10:0]] <= data_to_mem[7:0];
      end else if (half_word_to_mem) begin
        mem[{addr_to_mem[10:1], 1'b0}] <= data_to_mem[7:0];
        mem[{addr_to_mem[10:1], 1'b1}] <= data_to_mem[15:8];
      end else begin
        mem[{addr_to_mem[10:2], 2'd0}] <= data_to_mem[7:0];
        mem[{addr_to_mem[10:2], 2'd1}] <= data_to_mem[15:8];
        mem[{addr_to_mem[10:2], 2'd2}] <= data_to_mem[23:16];
        mem[{addr_to_mem[10:2], 2'd3}] <= data_to_mem[31:24];
      end
    end
  end

  typedef struct {
    logic        st_v;  logic [31:0] st_a;  logic [31:0] st_d;  logic st_b;  logic st_h;
    logic        ld_v;  logic [31:0] ld_a;  logic ld_b;  logic ld_h;  logic ld_s;
    logic        e_st_rdy;  logic e_ld_rdy;  logic chk_ld;  logic [31:0] e_ld_data;
    logic        e_empty;   logic e_we;      logic [31:0] e_addr;
    logic        chk_wd;    logic [31:0] e_wdata;
  } vec_t;

  localparam int NV = 12;
  vec_t vt [NV];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    st_valid = 1'b0; st_addr = '0; st_data = '0; st_byte = 1'b0; st_half_word = 1'b0;
    ld_valid = 1'b0; ld_addr = '0; ld_byte = 1'b0; ld_half_word = 1'b0; ld_sign_extend = 1'b0;
  endtask

  task automatic push_st(input logic [31:0] a, input logic [31:0] d);
    st_valid = 1'b1; st_addr = a; st_data = d; st_byte = 1'b0; st_half_word = 1'b0;
  endtask

  // Holds a non-hazarding word load at 0x100 so the buffer cannot drain.
  task automatic hold_load();
    ld_valid = 1'b1; ld_addr = 32'h100; ld_byte = 1'b0; ld_half_word = 1'b0; ld_sign_extend = 1'b0;
  endtask

  initial begin
    logic fwd;
    int   w0;
`ifdef STBUF_FWD_EN
    fwd = 1'b1;
`else
    fwd = 1'b0;
`endif
    vt[0]  = '{1'b0, 32'h0,  32'h0,        1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0,
               1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,  1'b0, 32'h0};
    vt[1]  = '{1'b1, 32'h40, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0,
               1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,  1'b0, 32'h0};
    vt[2]  = '{1'b0, 32'h0,  32'h0,        1'b0, 1'b0, 1'b1, 32'h40, 1'b0, 1'b0, 1'b0,
               1'b1, fwd,  fwd,  32'hDEADBEEF, 1'b0, 1'b1, 32'h40, 1'b1, 32'hDEADBEEF};
    vt[3]  = '{1'b0, 32'h0,  32'h0,        1'b0, 1'b0, 1'b1, 32'h40, 1'b0, 1'b0, 1'b0,
               1'b1, 1'b1, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 32'h40, 1'b0, 32'h0};
    vt[4]  = '{1'b1, 32'h41, 32'h80,       1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0,
               1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,  1'b0, 32'h0};
    vt[5]  = '{1'b0, 32'h0,  32'h0,        1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0,
               1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h41, 1'b1, 32'h80};
    vt[6]  = '{1'b0, 32'h0,  32'h0,        1'b0, 1'b0, 1'b1, 32'h41, 1'b1, 1'b0, 1'b1,
               1'b1, 1'b1, 1'b1, 32'hFFFFFF80, 1'b1, 1'b0, 32'h41, 1'b0, 32'h0};
    vt[7]  = '{1'b0, 32'h0,  32'h0,        1'b0, 1'b0, 1'b1, 32'h41, 1'b1, 1'b0, 1'b0,
               1'b1, 1'b1, 1'b1, 32'h00000080, 1'b1, 1'b0, 32'h41, 1'b0, 32'h0};
    vt[8]  = '{1'b1, 32'h42, 32'h1234,     1'b0, 1'b1, 1'b1, 32'h41, 1'b1, 1'b0, 1'b1,
               1'b1, 1'b1, 1'b1, 32'hFFFFFF80, 1'b1, 1'b0, 32'h41, 1'b0, 32'h0};
    vt[9]  = '{1'b0, 32'h0,  32'h0,        1'b0, 1'b0, 1'b1, 32'h42, 1'b0, 1'b1, 1'b0,
               1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h42, 1'b1, 32'h1234};
    vt[10] = '{1'b0, 32'h0,  32'h0,        1'b0, 1'b0, 1'b1, 32'h42, 1'b0, 1'b1, 1'b0,
               1'b1, 1'b1, 1'b1, 32'h00001234, 1'b1, 1'b0, 32'h42, 1'b0, 32'h0};
    vt[11] = '{1'b0, 32'h0,  32'h0,        1'b0, 1'b0, 1'b1, 32'h40, 1'b0, 1'b0, 1'b0,
               1'b1, 1'b1, 1'b1, 32'h123480EF, 1'b1, 1'b0, 32'h40, 1'b0, 32'h0};

    reset = 1'b0;
    idle_inputs();
    repeat (3) @(negedge clock);
    #1;
    chk("rst_empty", {31'h0, empty}, 32'h1);
    chk("rst_st_ready", {31'h0, st_ready}, 32'h1);
    chk("rst_we", {31'h0, write_enable_to_mem}, 32'h0);
    chk("rst_ld_ready", {31'h0, ld_ready}, 32'h0);
    @(negedge clock);
    reset = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge clock);
      st_valid = vt[i].st_v; st_addr = vt[i].st_a; st_data = vt[i].st_d;
      st_byte = vt[i].st_b; st_half_word = vt[i].st_h;
      ld_valid = vt[i].ld_v; ld_addr = vt[i].ld_a; ld_byte = vt[i].ld_b;
      ld_half_word = vt[i].ld_h; ld_sign_extend = vt[i].ld_s;
      #1;
      chk($sformatf("row%0d_st_ready", i), {31'h0, st_ready}, {31'h0, vt[i].e_st_rdy});
      chk($sformatf("row%0d_ld_ready", i), {31'h0, ld_ready}, {31'h0, vt[i].e_ld_rdy});
      if (vt[i].chk_ld) chk($sformatf("row%0d_ld_data", i), ld_data, vt[i].e_ld_data);
      chk($sformatf("row%0d_empty", i), {31'h0, empty}, {31'h0, vt[i].e_empty});
      chk($sformatf("row%0d_we", i), {31'h0, write_enable_to_mem}, {31'h0, vt[i].e_we});
      chk($sformatf("row%0d_addr", i), addr_to_mem, vt[i].e_addr);
      if (vt[i].chk_wd) chk($sformatf("row%0d_wdata", i), data_to_mem, vt[i].e_wdata);
    end

    // Fill under a held load, then drain four back-to-back writes in order.
    @(negedge clock);
    idle_inputs();
    hold_load();
    for (int k = 0; k < 4; k++) begin
      push_st(32'h200 + 32'(4 * k), 32'h10 + 32'(k));
      #1;
      chk($sformatf("fill%0d_st_ready", k), {31'h0, st_ready}, 32'h1);
      chk($sformatf("fill%0d_we", k), {31'h0, write_enable_to_mem}, 32'h0);
      @(negedge clock);
    end
    st_valid = 1'b0;
    #1;
    chk("full_st_ready", {31'h0, st_ready}, 32'h0);
    chk("full_ld_ready", {31'h0, ld_ready}, 32'h1);
    chk("full_ld_data", ld_data, 32'h0);
    @(negedge clock);
    ld_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("drain%0d_we", k), {31'h0, write_enable_to_mem}, 32'h1);
      chk($sformatf("drain%0d_addr", k), addr_to_mem, 32'h200 + 32'(4 * k));
      chk($sformatf("drain%0d_wdata", k), data_to_mem, 32'h10 + 32'(k));
      @(negedge clock);
    end
    #1;
    chk("drained_empty", {31'h0, empty}, 32'h1);
    chk("drained_we", {31'h0, write_enable_to_mem}, 32'h0);

    // Full buffer refuses a store even while its head drains; accepted one cycle later.
    @(negedge clock);
    hold_load();
    for (int k = 0; k < 4; k++) begin
      push_st(32'h200 + 32'(4 * k), 32'h20 + 32'(k));
      @(negedge clock);
    end
    ld_valid = 1'b0;
    push_st(32'h300, 32'h55);
    #1;
    chk("fullpush_st_ready", {31'h0, st_ready}, 32'h0);
    chk("fullpush_addr", addr_to_mem, 32'h200);
    @(negedge clock);
    #1;
    chk("retry_st_ready", {31'h0, st_ready}, 32'h1);
    chk("retry_addr", addr_to_mem, 32'h204);
    @(negedge clock);
    st_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("rest%0d_we", k), {31'h0, write_enable_to_mem}, 32'h1);
      chk($sformatf("rest%0d_addr", k), addr_to_mem, (k == 2) ? 32'h300 : 32'h208 + 32'(4 * k));
      @(negedge clock);
    end
    #1;
    chk("rest_empty", {31'h0, empty}, 32'h1);

    // Asynchronous reset with three pending stores discards them.
    @(negedge clock);
    hold_load();
    for (int k = 0; k < 3; k++) begin
      push_st(32'h400 + 32'(4 * k), 32'hA0 + 32'(k));
      @(negedge clock);
    end
    st_valid = 1'b0;
    #1;
    chk("pre_rst_empty", {31'h0, empty}, 32'h0);
    w0 = wr_cnt;
    #1;
    reset = 1'b0;
    #1;
    chk("midrst_empty", {31'h0, empty}, 32'h1);
    chk("midrst_st_ready", {31'h0, st_ready}, 32'h1);
    chk("midrst_we", {31'h0, write_enable_to_mem}, 32'h0);
    @(negedge clock);
    reset = 1'b1;
    ld_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("postrst%0d_we", k), {31'h0, write_enable_to_mem}, 32'h0);
      @(negedge clock);
    end
    chk("postrst_writes", 32'(wr_cnt - w0), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
